// File: rtl/lane_add_conn_multi.sv
// NEAT add-connection mutation lane: forwards genes, queues candidate sources and pairs them with later destinations.
// Optional NEAT_NO_SELF_LOOP_EN: a pop whose source equals the current destination is consumed without emitting.
module lane_add_conn_multi #(
    parameter int ATTR_SZ   = 8,
    parameter int GENE_SZ   = 8*ATTR_SZ,
    parameter int SRC_DEPTH = 4,
    parameter int MAX_ADD   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         state,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [GENE_SZ-1:0] gene_in,
    input  logic [ATTR_SZ-1:0] conn_add_prob,
    input  logic [ATTR_SZ-1:0] random,
    input  logic [ATTR_SZ-1:0] genome_id,
    input  logic [ATTR_SZ-1:0] new_weight,
    input  logic               out_ready,
    output logic [GENE_SZ-1:0] gene_out1,
    output logic [GENE_SZ-1:0] gene_out2,
    output logic [1:0]         out_valid,
    output logic [ATTR_SZ-1:0] hidden_node_max,
    output logic [ATTR_SZ-1:0] add_count
);

    localparam int PTR_W = $clog2(SRC_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int SUM_W = ATTR_SZ + 1;

    localparam logic [1:0] ST_PASS   = 2'b00;
    localparam logic [1:0] ST_MUTATE = 2'b10;

    localparam logic [OCC_W-1:0]   DEPTH_C  = OCC_W'(SRC_DEPTH);
    localparam logic [SUM_W-1:0]   MAX_C    = SUM_W'(MAX_ADD);
    localparam logic [ATTR_SZ-1:0] ADD_LIM  = ATTR_SZ'(MAX_ADD);
    localparam logic [ATTR_SZ-1:0] TYPE_NEW = {1'b1, {(ATTR_SZ-1){1'b0}}};
    localparam logic [ATTR_SZ-1:0] EN_ON    = ATTR_SZ'(1);

    typedef struct packed {
        logic [ATTR_SZ-1:0] gid;
        logic [ATTR_SZ-1:0] typ;
        logic [ATTR_SZ-1:0] src;
        logic [ATTR_SZ-1:0] dst;
        logic [ATTR_SZ-1:0] wgt;
        logic [ATTR_SZ-1:0] en;
        logic [ATTR_SZ-1:0] sp1;
        logic [ATTR_SZ-1:0] sp0;
    } gene_t;

    logic [SRC_DEPTH-1:0][ATTR_SZ-1:0] fifo_mem;
    logic [PTR_W-1:0]   rd_ptr, wr_ptr, nx_rd, nx_wr, push_idx;
    logic [OCC_W-1:0]   occ, nx_occ;
    logic [ATTR_SZ-1:0] lat_id, nx_lat, nx_hmax, nx_add;
    logic [GENE_SZ-1:0] nx_out1, nx_out2;
    logic [1:0]         nx_vld;
    logic               accept, push, emit_ok;
    logic [ATTR_SZ-1:0] in_src, in_dst, head_src;
    gene_t              syn;

    assign in_ready = (out_valid == 2'b00) | out_ready;
    assign accept   = in_valid & in_ready;
    assign in_src   = gene_in[5*ATTR_SZ +: ATTR_SZ];
    assign in_dst   = gene_in[4*ATTR_SZ +: ATTR_SZ];
    assign head_src = fifo_mem[rd_ptr];

    assign syn.gid = genome_id;
    assign syn.typ = TYPE_NEW;
    assign syn.src = head_src;
    assign syn.dst = in_dst;
    assign syn.wgt = new_weight;
    assign syn.en  = EN_ON;
    assign syn.sp1 = '0;
    assign syn.sp0 = '0;

`ifdef NEAT_NO_SELF_LOOP_EN
    assign emit_ok = (head_src != in_dst);
`else
    assign emit_ok = 1'b1;
`endif

    // Next-state: boundary flush, forward, pop-then-push, all resolved in one beat.
    always_comb begin
        nx_out1  = gene_out1;
        nx_out2  = gene_out2;
        nx_vld   = out_valid;
        nx_hmax  = hidden_node_max;
        nx_add   = add_count;
        nx_lat   = lat_id;
        nx_rd    = rd_ptr;
        nx_wr    = wr_ptr;
        nx_occ   = occ;
        push     = 1'b0;
        push_idx = wr_ptr;
        if (accept) begin
            case (state)
                ST_PASS: begin
                    nx_out1 = gene_in;
                    nx_out2 = '0;
                    nx_vld  = 2'b01;
                    if (in_src > nx_hmax) nx_hmax = in_src;
                    if (in_dst > nx_hmax) nx_hmax = in_dst;
                end
                ST_MUTATE: begin
                    if (genome_id != lat_id) begin
                        nx_rd   = '0;
                        nx_wr   = '0;
                        nx_occ  = '0;
                        nx_add  = '0;
                        nx_hmax = '0;
                        nx_lat  = genome_id;
                    end
                    nx_out1 = gene_in;
                    nx_out2 = '0;
                    nx_vld  = 2'b01;
                    if (in_src > nx_hmax) nx_hmax = in_src;
                    if (in_dst > nx_hmax) nx_hmax = in_dst;
                    // Pop sees only pre-push contents, so a gene never pairs with its own src.
                    if (nx_occ != '0) begin
                        nx_rd  = nx_rd + PTR_W'(1);
                        nx_occ = nx_occ - OCC_W'(1);
                        if (emit_ok) begin
                            nx_out2 = GENE_SZ'(syn);
                            nx_vld  = 2'b11;
                            if (nx_add < ADD_LIM) nx_add = nx_add + ATTR_SZ'(1);
                        end
                    end
                    if ((random > conn_add_prob) && (nx_occ < DEPTH_C) &&
                        (({1'b0, nx_add} + SUM_W'(nx_occ)) < MAX_C)) begin
                        push     = 1'b1;
                        push_idx = nx_wr;
                        nx_wr    = nx_wr + PTR_W'(1);
                        nx_occ   = nx_occ + OCC_W'(1);
                    end
                end
                default: begin
                    nx_out1 = '0;
                    nx_out2 = '0;
                    nx_vld  = 2'b00;
                    nx_rd   = '0;
                    nx_wr   = '0;
                    nx_occ  = '0;
                    nx_add  = '0;
                    nx_hmax = '0;
                end
            endcase
        end else if (in_ready) begin
            nx_out1 = '0;
            nx_out2 = '0;
            nx_vld  = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gene_out1       <= '0;
            gene_out2       <= '0;
            out_valid       <= 2'b00;
            hidden_node_max <= '0;
            add_count       <= '0;
            lat_id          <= '0;
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            occ             <= '0;
        end else begin
            gene_out1       <= nx_out1;
            gene_out2       <= nx_out2;
            out_valid       <= nx_vld;
            hidden_node_max <= nx_hmax;
            add_count       <= nx_add;
            lat_id          <= nx_lat;
            rd_ptr          <= nx_rd;
            wr_ptr          <= nx_wr;
            occ             <= nx_occ;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_mem <= '0;
        end else if (push) begin
            fifo_mem[push_idx] <= in_src;
        end
    end

endmodule
